// File: rtl/game_pkg.sv
// Shared types and constants for the jump-game datapath blocks.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    WIN  = 2'd3
  } sched_state_t;

  localparam int         X_W       = 10;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam int         SCREEN_W  = 640;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1); advances only when step is high.
module lfsr8
  import game_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       step,
  output logic [7:0] q
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (step) q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) q_q <= LFSR_SEED;
    else          q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/obstacle_scheduler.sv
// Obstacle pool for the jump game: spawn, scroll, retire/score, and
// player collision / win detection feeding the game FSM and renderer.
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int SCREEN_W   = game_pkg::SCREEN_W,
  parameter int SPEED      = 4,
  parameter int OBJ_W      = 20,
  parameter int PLAYER_X   = 100,
  parameter int PLAYER_W   = 20,
  parameter int JUMP_CLEAR = 40,
  parameter int MIN_GAP    = 160,
  parameter int WIN_COUNT  = 20
) (
  input  logic                    CLOCK_50,
  input  logic                    reset_n,
  input  logic                    game_tick,
  input  logic                    start,
  input  logic [9:0]              distance,
  output logic [NUM_SLOTS*10-1:0] obj_x,
  output logic [NUM_SLOTS-1:0]    obj_valid,
  output logic [7:0]              score,
  output logic                    player_hit,
  output logic                    player_won,
  output logic                    running
);

  localparam int CNT_W       = $clog2(NUM_SLOTS + 1);
  localparam int GAP_START_I = (MIN_GAP + 63 > 1023) ? 1023 : MIN_GAP + 63;

  localparam logic [X_W-1:0] SPAWN_X   = X_W'(SCREEN_W - 1);
  localparam logic [X_W-1:0] SPEED_X   = X_W'(SPEED);
  localparam logic [10:0]    SPEED_11  = 11'(SPEED);
  localparam logic [10:0]    OBJ_W_11  = 11'(OBJ_W);
  localparam logic [10:0]    PX_11     = 11'(PLAYER_X);
  localparam logic [10:0]    PEND_11   = 11'(PLAYER_X + PLAYER_W);
  localparam logic [10:0]    MIN_GAP_11 = 11'(MIN_GAP);
  localparam logic [9:0]     JUMP_10   = 10'(JUMP_CLEAR);
  localparam logic [7:0]     WIN_8     = 8'(WIN_COUNT);
  localparam logic [9:0]     GAP_START = 10'(GAP_START_I);

  sched_state_t                  state_q, state_d;
  logic [NUM_SLOTS-1:0][X_W-1:0] x_q, x_d, x_moved;
  logic [NUM_SLOTS-1:0]          valid_q, valid_d, retire, kept, overlap;
  logic [7:0]                    score_q, score_d;
  logic [9:0]                    gap_q, gap_d;
  logic                          hit_q, won_q, run_q;
  logic [7:0]                    lfsr;
  logic                          tick_run, hit_cond, spawn_due, spawned;
  logic [CNT_W-1:0]              retire_cnt;
  logic [8:0]                    score_sum;
  logic [10:0]                   gap_sum, gap_thr;

  assign tick_run = game_tick && (state_q == RUN);

  lfsr8 u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .step     (tick_run),
    .q        (lfsr)
  );

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    logic [10:0] x_ext;
    assign x_ext      = {1'b0, x_q[i]};
    assign retire[i]  = valid_q[i] && (x_q[i] < SPEED_X);
    assign kept[i]    = valid_q[i] && !retire[i];
    assign x_moved[i] = kept[i] ? x_q[i] - SPEED_X : x_q[i];
    assign overlap[i] = valid_q[i] && (x_ext + OBJ_W_11 > PX_11) && (x_ext < PEND_11);
  end

  assign hit_cond  = (|overlap) && (distance < JUMP_10);
  assign score_sum = {1'b0, score_q} + 9'(retire_cnt);
  assign gap_thr   = MIN_GAP_11 + {5'b0, lfsr[5:0]};
  assign spawn_due = {1'b0, gap_q} >= gap_thr;
  assign gap_sum   = {1'b0, gap_q} + SPEED_11;

  always_comb begin
    retire_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) retire_cnt = retire_cnt + CNT_W'(retire[i]);
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    valid_d = valid_q;
    score_d = score_q;
    gap_d   = gap_q;
    spawned = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = '0;
          valid_d = '0;
          score_d = '0;
          gap_d   = GAP_START;
        end
      end
      RUN: begin
        if (game_tick) begin
          x_d     = x_moved;
          valid_d = kept;
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
          // Spawn sees slots freed by this tick's retirements.
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (spawn_due && !spawned && !kept[i]) begin
              x_d[i]     = SPAWN_X;
              valid_d[i] = 1'b1;
              spawned    = 1'b1;
            end
          end
          gap_d = spawned ? '0 : ((gap_sum > 11'd1023) ? 10'd1023 : gap_sum[9:0]);
        end
        if (hit_cond)               state_d = HIT;
        else if (score_q >= WIN_8)  state_d = WIN;
      end
      HIT, WIN: begin
        if (start) begin
          state_d = IDLE;
          x_d     = '0;
          valid_d = '0;
          score_d = '0;
          gap_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      valid_q <= '0;
      score_q <= '0;
      gap_q   <= '0;
      hit_q   <= 1'b0;
      won_q   <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      score_q <= score_d;
      gap_q   <= gap_d;
      hit_q   <= (state_d == HIT);
      won_q   <= (state_d == WIN);
      run_q   <= (state_d == RUN);
    end
  end

  assign obj_x      = x_q;
  assign obj_valid  = valid_q;
  assign score      = score_q;
  assign player_hit = hit_q;
  assign player_won = won_q;
  assign running    = run_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench: default-parameter instance plus a dense-spawn instance and a
// hit/win priority instance sharing one clock and reset.
module tb_obstacle_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tick_a, tick_b, tick_c, start_a, start_b, start_c;
  logic [9:0] dist_a, dist_b, dist_c;
  logic [39:0] x_a, x_b, x_c;
  logic [3:0]  v_a, v_b, v_c;
  logic [7:0]  score_a, score_b, score_c;
  logic        hit_a, hit_b, hit_c, won_a, won_b, won_c, run_a, run_b, run_c;

  int n_cmp = 0;
  int n_bad = 0;

  obstacle_scheduler dut_a (
    .CLOCK_50(clk), .reset_n(rst_n), .game_tick(tick_a), .start(start_a),
    .distance(dist_a), .obj_x(x_a), .obj_valid(v_a), .score(score_a),
    .player_hit(hit_a), .player_won(won_a), .running(run_a)
  );

  obstacle_scheduler #(.MIN_GAP(0)) dut_b (
    .CLOCK_50(clk), .reset_n(rst_n), .game_tick(tick_b), .start(start_b),
    .distance(dist_b), .obj_x(x_b), .obj_valid(v_b), .score(score_b),
    .player_hit(hit_b), .player_won(won_b), .running(run_b)
  );

  obstacle_scheduler #(.MIN_GAP(0), .WIN_COUNT(1), .PLAYER_X(0), .PLAYER_W(30)) dut_c (
    .CLOCK_50(clk), .reset_n(rst_n), .game_tick(tick_c), .start(start_c),
    .distance(dist_c), .obj_x(x_c), .obj_valid(v_c), .score(score_c),
    .player_hit(hit_c), .player_won(won_c), .running(run_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      case (which)
        0:       tick_a = 1'b1;
        1:       tick_b = 1'b1;
        default: tick_c = 1'b1;
      endcase
      @(negedge clk);
      tick_a = 1'b0; tick_b = 1'b0; tick_c = 1'b0;
    end
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    case (which)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  initial begin
    logic [39:0] saved;
    int guard;
    rst_n = 1'b0;
    tick_a = 0; tick_b = 0; tick_c = 0;
    start_a = 0; start_b = 0; start_c = 0;
    dist_a = 10'd40; dist_b = 10'd40; dist_c = 10'd40;
    repeat (3) @(negedge clk);
    chk("rst_valid", v_a, 0);
    chk("rst_x", x_a, 0);
    chk("rst_score", score_a, 0);
    chk("rst_hit", hit_a, 0);
    chk("rst_won", won_a, 0);
    chk("rst_run", run_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Pool full with MIN_GAP=0: fill, defer, then refill on first retirement.
    pulse_start(1);
    guard = 0;
    while (v_b != 4'hF && guard < 200) begin tick(1, 1); guard++; end
    chk("pool_full", v_b, 4'hF);
    tick(1, 1);
    chk("defer_valid", v_b, 4'hF);
    for (int i = 0; i < 4; i++) chk("defer_no_spawn", (x_b[i*10 +: 10] == 10'd639), 0);
    guard = 0;
    while (score_b == 0 && guard < 300) begin tick(1, 1); guard++; end
    chk("refill_score", score_b, 1);
    chk("refill_valid", v_b, 4'hF);
    chk("refill_x0", x_b[9:0], 639);

    // Hit beats win: slot1 (spawned tick 7) overlaps as slot0 retires on tick 161.
    pulse_start(2);
    tick(2, 160);
    chk("c_x0_pre", x_c[9:0], 3);
    chk("c_x1_pre", x_c[19:10], 27);
    tick(2, 1);
    dist_c = 10'd0;
    chk("c_score", score_c, 1);
    chk("c_x1", x_c[19:10], 23);
    @(negedge clk);
    chk("c_hit", hit_c, 1);
    chk("c_won", won_c, 0);

    // Main run on default parameters, jumping clear of every obstacle.
    pulse_start(0);
    chk("start_run", run_a, 1);
    chk("start_valid", v_a, 0);
    tick(0, 1);
    chk("spawn_valid0", v_a[0], 1);
    chk("spawn_x0", x_a[9:0], 639);
    chk("spawn_score", score_a, 0);
    tick(0, 130);
    chk("move_x119", x_a[9:0], 119);
    @(negedge clk);
    chk("clear_no_hit", hit_a, 0);
    chk("clear_run", run_a, 1);
    tick(0, 29);
    chk("move_x3", x_a[9:0], 3);
    chk("move_valid0", v_a[0], 1);
    tick(0, 1);
    chk("retire_score", score_a, 1);
    chk("retire_slot0", (!v_a[0] || x_a[9:0] == 10'd639), 1);
    guard = 0;
    while (!won_a && guard < 3000) begin tick(0, 1); guard++; end
    chk("win_won", won_a, 1);
    chk("win_score", score_a, 20);
    chk("win_hit", hit_a, 0);
    chk("win_run", run_a, 0);
    saved = x_a;
    tick(0, 3);
    chk("win_frozen", x_a, saved);
    pulse_start(0);
    chk("win_idle_won", won_a, 0);
    chk("win_idle_score", score_a, 0);
    chk("win_idle_valid", v_a, 0);

    // Collision with distance 0: overlap begins when x reaches 119.
    pulse_start(0);
    dist_a = 10'd0;
    tick(0, 1);
    chk("hit_spawn_x0", x_a[9:0], 639);
    tick(0, 129);
    chk("hit_x123", x_a[9:0], 123);
    chk("hit_before", hit_a, 0);
    tick(0, 1);
    chk("hit_same_cycle", hit_a, 0);
    @(negedge clk);
    chk("hit_asserted", hit_a, 1);
    chk("hit_not_run", run_a, 0);
    saved = x_a;
    tick(0, 2);
    chk("hit_frozen", x_a, saved);

    // Restart from HIT, then asynchronous reset mid-run.
    pulse_start(0);
    chk("hit_idle_hit", hit_a, 0);
    chk("hit_idle_valid", v_a, 0);
    chk("hit_idle_x", x_a, 0);
    chk("hit_idle_run", run_a, 0);
    pulse_start(0);
    chk("restart_run", run_a, 1);
    tick(0, 3);
    chk("restart_valid", v_a, 4'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", v_a, 0);
    chk("async_x", x_a, 0);
    chk("async_run", run_a, 0);
    chk("async_score", score_a, 0);
    #5 rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
